pc_fetch_unit: RTL

- Owns the program counter register and drives instruction-memory fetches.
- Sits on the other end of the PC+4 incrementer: it supplies PCResult to the adder and consumes PCAddResult as the sequential next PC.
- Handles branch/jump redirect, downstream stall and a req/ack handshake to instruction memory.
- Presents a registered instruction plus its PC to the IF/ID boundary.

---
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner and instruction fetch front end (optional PC_MISALIGN_TRAP_EN)
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] PCAddResult,
    output logic [ADDR_W-1:0] PCResult,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Stall,
    output logic              ImemReq,
    input  logic              ImemAck,
    input  logic [DATA_W-1:0] ImemData,
    output logic [DATA_W-1:0] Instruction,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              InstrValid
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic              MisalignErr
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic              trap_q;
    logic [ADDR_W-1:0] branch_tgt;
    logic              slot_free;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign    = |BranchTarget[1:0];
    assign branch_tgt  = BranchTarget;
    assign MisalignErr = trap_q;
`else
    // Without the trap, a misaligned target is silently word-aligned.
    assign branch_tgt  = BranchTarget & ~ADDR_W'(3);
    assign trap_q      = 1'b0;
`endif

    // The IF/ID slot can take a new word if it is empty or being drained now.
    assign slot_free = !valid_q || !Stall;

    // Request follows Stall in the same cycle so a stalled full slot never sees an ack.
    assign ImemReq = (state_q == ST_REQ) && slot_free;

    assign PCResult    = pc_q;
    assign Instruction = instr_q;
    assign InstrPC     = instr_pc_q;
    assign InstrValid  = valid_q;

    // Fetch FSM: branch redirect beats everything, then capture, hold and drain.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else if (trap_q) begin
            // A trapped unit parks in HOLD until the next reset.
            state_q <= ST_HOLD;
            valid_q <= 1'b0;
        end else if (BranchTaken) begin
            valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            if (misalign) begin
                trap_q  <= 1'b1;
                state_q <= ST_HOLD;
            end else begin
                pc_q    <= branch_tgt;
                state_q <= ST_REQ;
            end
`else
            pc_q    <= branch_tgt;
            state_q <= ST_REQ;
`endif
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_REQ;
                ST_REQ: begin
                    if (!slot_free) begin
                        state_q <= ST_HOLD;
                    end else if (ImemAck) begin
                        instr_q    <= ImemData;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        pc_q       <= PCAddResult;
                    end else begin
                        // slot_free with no capture: any held entry is drained this edge.
                        valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        state_q <= ST_REQ;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
